i2s_row_streamer: RTL
=====================

Name: i2s_row_streamer

Overview:
Transmit end of the node I2S row stream. On each start request it emits one row frame: a 16-bit header {num_modules_x, num_modules_y, 2'b00, row_num} followed by one 16-bit word per module. All fields are MSB first on i2s_data, qualified by a generated i2s_clk. Row payload words are fetched from an external synchronous word buffer (1-cycle read latency). The block sits between the frame/row buffer and the shared i2s_clk/i2s_data bus that feeds all node `top` instances.

Parameters:
HALF_DIV, 4, clk cycles per i2s_clk phase (low and high); legal range >=1; bit period = 2*HALF_DIV.
NUM_ROWS, 8, row counter modulus; legal range 1..64.
ADDR_W, 8, word_addr width; must hold 256 words (16x16 modules).

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  request one row frame; sampled only when busy=0
num_modules_x  in  4  modules in X minus 1; latched at start
num_modules_y  in  4  modules in Y minus 1; latched at start
word_rd_en  out  1  one-cycle read strobe to word buffer
word_addr  out  ADDR_W  word index, 0..N-1, where N=(nx+1)*(ny+1)
word_rdata  in  16  buffer data; valid the cycle after word_rd_en
i2s_clk  out  1  serial bit clock (registered, not gated)
i2s_data  out  1  serial data; changes only at the start of a low phase
busy  out  1  high from start acceptance through the last high phase
frame_done  out  1  one-cycle pulse when a frame completes
row_num  out  6  current row index, inserted into the header

Behaviour:
- Reset values: i2s_clk=0, i2s_data=0, busy=0, frame_done=0, word_rd_en=0, word_addr=0, row_num=0, FSM=IDLE. Reset is asynchronous. Reset mid-frame aborts the frame immediately: no frame_done pulse, and row_num is not incremented beyond 0.
- FSM states: IDLE -> HDR (16 bits) -> DATA (16*N bits) -> IDLE.
- IDLE, start=1 at cycle T:
  - Latch nx, ny and the header.
  - At T+1: busy=1, FSM=HDR, i2s_clk=0, i2s_data=header[15], word_rd_en=1, word_addr=0.
  - At T+2: capture word_rdata into the prefetch register.
- Bit timing:
  - Each bit is HALF_DIV cycles with i2s_clk=0, then HALF_DIV cycles with i2s_clk=1.
  - The next bit is driven on the cycle i2s_clk returns to 0.
  - Receivers sample on the i2s_clk rising edge.
- Header to data transition: after header bit 0, load the prefetch register into the 16-bit shifter. In that same cycle pulse word_rd_en for word_addr=1 (if N>1).
- Data words: each word load issues the read for the next word. Words beyond N-1 are never read. Total reads per frame = N.
- Frame end: after the high phase of the last data bit, in the same cycle:
  - i2s_clk=0, i2s_data=0, busy=0, frame_done=1.
  - row_num <= (row_num==NUM_ROWS-1) ? 0 : row_num+1.
- Frame length: (16+16N)*2*HALF_DIV cycles from the first low phase to busy falling.
- start while busy=1 is ignored (not queued). start in the frame_done cycle is accepted, since busy=0.
- Changes to nx/ny while busy have no effect on the current frame.
- i2s_clk idles low. No clock edges occur outside a frame.
- Width rules:
  - N is computed as 9-bit (nx+1)*(ny+1), maximum 256.
  - word_addr is compared against N-1 at ADDR_W bits.

Decomposition:
- Package i2s_stream_pkg:
  - HDR_BITS=16, WORD_BITS=16.
  - Header field widths: MX_W=4, MY_W=4, PAD_W=2, ROW_W=6.
  - FSM state typedef {IDLE, HDR, DATA}.
  - A header-pack function.
- One sub-module, i2s_bit_timer: HALF_DIV phase counter. Outputs the i2s_clk level, bit_start (first cycle of low phase) and bit_end (last cycle of high phase) strobes. Enabled by busy.

Test Plan:
- HALF_DIV=4, nx=ny=3, start once at row 0:
  - Header bits = 0x3300.
  - 16 reads at addr 0..15, each exactly once.
  - 272 bits, busy high 2176 cycles.
  - Serial payload equals the buffer contents MSB first.
  - frame_done pulses once; row_num becomes 1.
- 8 back-to-back frames with nx=ny=3 and start held high: headers 0x3300..0x3307; after the 8th, row_num=0 and the 9th header is 0x3300.
- nx=ny=0, word 0 = 0xA5C3: header 0x0000+row, then bits 1010010111000011; exactly one read; 32 bits total.
- nx=15, ny=15, HALF_DIV=1: N=256, addresses 0..255, no address wrap, busy 8224 cycles.
- start pulsed mid-frame and nx changed mid-frame: no effect on timing, header or read count.
- rst_n low at bit 100 of a frame: outputs go to reset values immediately without waiting for clk, no frame_done, row_num=0. A subsequent start produces header row 0.

Source files
------------

// File: rtl/i2s_stream_pkg.sv
// Shared constants, FSM state type and header/frame-size helpers for the
// I2S row stream transmitter.
package i2s_stream_pkg;

  localparam int HDR_BITS  = 16;
  localparam int WORD_BITS = 16;

  // Header field widths: {num_modules_x, num_modules_y, pad, row}
  localparam int MX_W  = 4;
  localparam int MY_W  = 4;
  localparam int PAD_W = 2;
  localparam int ROW_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_e;

  // Build the 16-bit row header; the pad bits are always zero.
  function automatic logic [HDR_BITS-1:0] pack_header(
    input logic [MX_W-1:0]  nx,
    input logic [MY_W-1:0]  ny,
    input logic [ROW_W-1:0] row
  );
    return {nx, ny, {PAD_W{1'b0}}, row};
  endfunction

  // Number of payload words N = (nx+1)*(ny+1); at most 256, so 9 bits.
  function automatic logic [8:0] frame_words(
    input logic [MX_W-1:0] nx,
    input logic [MY_W-1:0] ny
  );
    logic [9:0] prod;
    prod = ({6'd0, nx} + 10'd1) * ({6'd0, ny} + 10'd1);
    return prod[8:0];
  endfunction

endpackage

// File: rtl/i2s_bit_timer.sv
// Bit-phase counter for the serial clock: HALF_DIV cycles low, HALF_DIV
// cycles high per bit. Held at the start of a low phase while disabled so
// the first enabled cycle is always the first cycle of a bit.
module i2s_bit_timer #(
  parameter int HALF_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic sclk_o,
  output logic bit_start_o,
  output logic bit_end_o
);

  localparam int PERIOD = 2 * HALF_DIV;
  localparam int CNT_W  = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(HALF_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;

  // Next phase count and the clock level that goes with it.
  always_comb begin
    cnt_d  = '0;
    sclk_d = 1'b0;
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      sclk_d = (cnt_d >= HALF);
    end
  end

  // Phase counter and registered serial clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  // Strobes for the first low-phase cycle and the last high-phase cycle.
  always_comb begin
    bit_start_o = en_i && (cnt_q == '0);
    bit_end_o   = en_i && (cnt_q == LAST);
  end

  assign sclk_o = sclk_q;

endmodule

// File: rtl/i2s_row_streamer.sv
// Row frame transmitter: serialises a header and N payload words, MSB first,
// fetching each payload word one word ahead from a 1-cycle-latency buffer.
module i2s_row_streamer
  import i2s_stream_pkg::*;
#(
  parameter int HALF_DIV = 4,
  parameter int NUM_ROWS = 8,
  parameter int ADDR_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [MX_W-1:0]      num_modules_x,
  input  logic [MY_W-1:0]      num_modules_y,
  output logic                 word_rd_en,
  output logic [ADDR_W-1:0]    word_addr,
  input  logic [WORD_BITS-1:0] word_rdata,
  output logic                 i2s_clk,
  output logic                 i2s_data,
  output logic                 busy,
  output logic                 frame_done,
  output logic [ROW_W-1:0]     row_num
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

  state_e                 state_q;
  logic                   busy_q;
  logic                   data_q;
  logic                   done_q;
  logic                   rd_en_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [ROW_W-1:0]       row_q;
  logic [WORD_BITS-1:0]   shift_q;
  logic [3:0]             bit_idx_q;
  logic [ADDR_W-1:0]      word_idx_q;
  logic [ADDR_W-1:0]      last_addr_q;
  logic [WORD_BITS-1:0]   prefetch_q;
  logic                   pf_pend_q;

  logic [HDR_BITS-1:0]    hdr_s;
  logic [8:0]             n_m1_s;
  logic [ADDR_W-1:0]      last_addr_s;
  logic                   bit_start_s;
  logic                   bit_end_s;
  logic                   sclk_s;

  assign hdr_s       = pack_header(num_modules_x, num_modules_y, row_q);
  assign n_m1_s      = frame_words(num_modules_x, num_modules_y) - 9'd1;
  assign last_addr_s = ADDR_W'(n_m1_s);

  i2s_bit_timer #(
    .HALF_DIV (HALF_DIV)
  ) u_bit_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (busy_q),
    .sclk_o      (sclk_s),
    .bit_start_o (bit_start_s),
    .bit_end_o   (bit_end_s)
  );

  // Capture buffer data the cycle after each read strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_pend_q  <= 1'b0;
      prefetch_q <= '0;
    end else begin
      pf_pend_q <= rd_en_q;
      if (pf_pend_q) begin
        prefetch_q <= word_rdata;
      end else begin
        prefetch_q <= prefetch_q;
      end
    end
  end

  // Frame FSM: start acceptance, bit shifting, word loads and read issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      data_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      row_q       <= '0;
      shift_q     <= '0;
      bit_idx_q   <= 4'd0;
      word_idx_q  <= '0;
      last_addr_q <= '0;
    end else begin
      done_q <= 1'b0;
      // A read strobe lasts until the first cycle of the bit it was issued in.
      rd_en_q <= rd_en_q && !bit_start_s;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= HDR;
            busy_q      <= 1'b1;
            data_q      <= hdr_s[HDR_BITS-1];
            shift_q     <= {hdr_s[HDR_BITS-2:0], 1'b0};
            bit_idx_q   <= 4'd15;
            rd_en_q     <= 1'b1;
            addr_q      <= '0;
            word_idx_q  <= '0;
            last_addr_q <= last_addr_s;
          end else begin
            busy_q <= 1'b0;
            data_q <= 1'b0;
          end
        end
        HDR, DATA: begin
          if (bit_end_s) begin
            if (bit_idx_q != 4'd0) begin
              data_q    <= shift_q[WORD_BITS-1];
              shift_q   <= {shift_q[WORD_BITS-2:0], 1'b0};
              bit_idx_q <= bit_idx_q - 4'd1;
            end else if ((state_q == DATA) && (word_idx_q == last_addr_q)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              data_q  <= 1'b0;
              done_q  <= 1'b1;
              row_q   <= (row_q == ROW_LAST) ? '0 : row_q + 6'd1;
            end else begin
              // Word boundary: load the prefetched word and fetch the next one.
              state_q    <= DATA;
              data_q     <= prefetch_q[WORD_BITS-1];
              shift_q    <= {prefetch_q[WORD_BITS-2:0], 1'b0};
              bit_idx_q  <= 4'd15;
              word_idx_q <= (state_q == HDR) ? '0 : word_idx_q + ADDR_W'(1);
              if (addr_q != last_addr_q) begin
                addr_q  <= addr_q + ADDR_W'(1);
                rd_en_q <= 1'b1;
              end else begin
                addr_q <= addr_q;
              end
            end
          end else begin
            data_q <= data_q;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          data_q  <= 1'b0;
        end
      endcase
    end
  end

  assign word_rd_en = rd_en_q;
  assign word_addr  = addr_q;
  assign i2s_clk    = sclk_s;
  assign i2s_data   = data_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign row_num    = row_q;

endmodule
